// File: rtl/series_pipe_engine_if.sv
// Handshake bundle for series_pipe_engine: sample in, result out, status.
interface series_pipe_engine_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_overflow;
  logic             busy;

  // Producer/consumer side (bench or upstream/downstream logic)
  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow, busy
  );

  // Engine side
  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_sum, out_overflow, busy
  );
endinterface

// File: rtl/series_pipe_engine.sv
// Recirculating fixed-point power-series engine.
// STAGES registered MAC stages form a ring; each sample makes PASSES trips
// round the ring, picking coefficient c[pass*STAGES+stage] at every stage.
// All arithmetic saturates; any clamp sets the sample's sticky overflow bit.

// One MAC step, purely combinational: term = c*num, sum += term, num *= x.
module series_mac_stage #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 31,
  parameter int STAGES = 4,
  parameter int PASSES = 2,
  parameter int PW     = 1,
  parameter int K      = 0,
  parameter logic [STAGES*PASSES*WIDTH-1:0] COEFS = '0
)(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] sum,
  input  logic             ovf,
  input  logic [PW-1:0]    pass,
  output logic [WIDTH-1:0] num_n,
  output logic [WIDTH-1:0] sum_n,
  output logic             ovf_n
);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]          coef, term;
  logic signed [2*WIDTH-1:0] coef_w, num_w, x_w;
  logic signed [2*WIDTH-1:0] p_term, p_num, s_term, s_num;
  logic signed [WIDTH:0]     acc;
  logic                      t_ovf, n_ovf, a_ovf;

  // Coefficient select, products, shifts and clamps for this stage
  always_comb begin
    coef = '0;
    for (int p = 0; p < PASSES; p++)
      if (pass == PW'(p)) coef = COEFS[(p*STAGES+K)*WIDTH +: WIDTH];

    coef_w = {{WIDTH{coef[WIDTH-1]}}, coef};
    num_w  = {{WIDTH{num[WIDTH-1]}},  num};
    x_w    = {{WIDTH{x[WIDTH-1]}},    x};
    p_term = coef_w * num_w;
    p_num  = num_w * x_w;
    s_term = p_term >>> FRAC;
    s_num  = p_num  >>> FRAC;

    // Shifted product fits iff its top WIDTH+1 bits are all equal
    t_ovf = !((&s_term[2*WIDTH-1:WIDTH-1]) || !(|s_term[2*WIDTH-1:WIDTH-1]));
    n_ovf = !((&s_num[2*WIDTH-1:WIDTH-1])  || !(|s_num[2*WIDTH-1:WIDTH-1]));
    term  = t_ovf ? (s_term[2*WIDTH-1] ? SMIN : SMAX) : s_term[WIDTH-1:0];
    num_n = n_ovf ? (s_num[2*WIDTH-1]  ? SMIN : SMAX) : s_num[WIDTH-1:0];

    acc   = $signed({sum[WIDTH-1], sum}) + $signed({term[WIDTH-1], term});
    a_ovf = acc[WIDTH] ^ acc[WIDTH-1];
    sum_n = a_ovf ? (acc[WIDTH] ? SMIN : SMAX) : acc[WIDTH-1:0];
    ovf_n = ovf | t_ovf | n_ovf | a_ovf;
  end
endmodule

module series_pipe_engine #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 31,
  parameter int STAGES = 4,
  parameter int PASSES = 2,
  parameter logic [STAGES*PASSES*WIDTH-1:0] COEFS = {
    32'hF0000000, 32'h12492492, 32'hEAAAAAAB, 32'h19999999,
    32'hE0000000, 32'h2AAAAAAA, 32'hC0000000, 32'h7FFFFFFF}
)(
  input  logic clk,
  input  logic rst,
  series_pipe_engine_if.slave bus
);
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int LS = STAGES - 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  // vld_pipe[STAGES] is the output register's valid
  logic [STAGES:0]              vld_pipe;
  logic [STAGES-1:0][WIDTH-1:0] x_q, num_q, sum_q;
  logic [STAGES-1:0]            ovf_q;
  logic [STAGES-1:0][PW-1:0]    pass_q;

  logic [STAGES-1:0][WIDTH-1:0] x_d, num_d, sum_d;
  logic [STAGES-1:0]            ovf_d, vld_d;
  logic [STAGES-1:0][PW-1:0]    pass_d;

  logic [STAGES-1:0][WIDTH-1:0] num_m, sum_m;
  logic [STAGES-1:0]            ovf_m;

  logic             en, recirc, take, done;
  logic [WIDTH-1:0] sum_o;
  logic             ovf_o;

  // A held, unconsumed result freezes the whole ring
  assign en     = !vld_pipe[STAGES] || bus.out_ready;
  assign recirc = vld_pipe[LS] && (pass_q[LS] != LAST_PASS);
  assign done   = vld_pipe[LS] && (pass_q[LS] == LAST_PASS);
  // Depends on state only, never on in_valid
  assign bus.in_ready = en && !recirc;
  assign take         = bus.in_valid && bus.in_ready;

  // Stage inputs: ring slot 0 prefers the recirculating sample over a new one
  always_comb begin
    x_d = '0; num_d = '0; sum_d = '0; ovf_d = '0; vld_d = '0; pass_d = '0;
    if (recirc) begin
      x_d[0]    = x_q[LS];
      num_d[0]  = num_q[LS];
      sum_d[0]  = sum_q[LS];
      ovf_d[0]  = ovf_q[LS];
      pass_d[0] = pass_q[LS] + PW'(1);
      vld_d[0]  = 1'b1;
    end else if (take) begin
      x_d[0]    = bus.in_x;
      num_d[0]  = bus.in_x;
      vld_d[0]  = 1'b1;
    end
    for (int k = 1; k < STAGES; k++) begin
      x_d[k]    = x_q[k-1];
      num_d[k]  = num_q[k-1];
      sum_d[k]  = sum_q[k-1];
      ovf_d[k]  = ovf_q[k-1];
      pass_d[k] = pass_q[k-1];
      vld_d[k]  = vld_pipe[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    series_mac_stage #(
      .WIDTH(WIDTH), .FRAC(FRAC), .STAGES(STAGES), .PASSES(PASSES),
      .PW(PW), .K(k), .COEFS(COEFS)
    ) u_mac (
      .x(x_d[k]), .num(num_d[k]), .sum(sum_d[k]), .ovf(ovf_d[k]),
      .pass(pass_d[k]),
      .num_n(num_m[k]), .sum_n(sum_m[k]), .ovf_n(ovf_m[k])
    );
  end

  // Stage and output registers; everything holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      x_q      <= '0;
      num_q    <= '0;
      sum_q    <= '0;
      ovf_q    <= '0;
      pass_q   <= '0;
      sum_o    <= '0;
      ovf_o    <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_pipe[k] <= vld_d[k];
        x_q[k]      <= x_d[k];
        num_q[k]    <= num_m[k];
        sum_q[k]    <= sum_m[k];
        ovf_q[k]    <= ovf_m[k];
        pass_q[k]   <= pass_d[k];
      end
      vld_pipe[STAGES] <= done;
      if (done) begin
        sum_o <= sum_q[LS];
        ovf_o <= ovf_q[LS];
      end
    end
  end

  assign bus.out_valid    = vld_pipe[STAGES];
  assign bus.out_sum      = sum_o;
  assign bus.out_overflow = ovf_o;
  assign bus.busy         = |vld_pipe;
endmodule

// File: tb/tb_series_pipe_engine.sv
// Scoreboard bench for series_pipe_engine (default parameters).
// Inputs change on the falling edge; in_ready is sampled 1ns later and the
// output monitor samples 2ns after the falling edge.
module tb_series_pipe_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  series_pipe_engine_if #(.WIDTH(32)) bus();

  series_pipe_engine dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];   // {overflow, sum}

  localparam logic [31:0] CT [8] = '{32'h7FFFFFFF, 32'hC0000000, 32'h2AAAAAAA,
    32'hE0000000, 32'h19999999, 32'hEAAAAAAB, 32'h12492492, 32'hF0000000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Reference: sum_n c_n * x^(n+1), Q1.31, saturating at every step
  function automatic logic [32:0] model(input logic [31:0] xin);
    longint x, num, sum, c, t, r;
    bit ovf;
    x = longint'($signed(xin)); num = x; sum = 0; ovf = 0;
    for (int n = 0; n < 8; n++) begin
      c = longint'($signed(CT[n]));
      t = (c * num) >>> 31;   r = clamp(t);   ovf |= (r != t); t = r;
      r = clamp(sum + t);     ovf |= (r != sum + t); sum = r;
      t = (num * x) >>> 31;   r = clamp(t);   ovf |= (r != t); num = r;
    end
    return {ovf, sum[31:0]};
  endfunction

  // Monitor: every output handshake pops and checks one expected result
  initial begin
    forever begin
      @(negedge clk); #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", {31'd0, bus.out_overflow, bus.out_sum}, 64'hDEAD);
        else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("out_sum", {32'd0, bus.out_sum}, {32'd0, e[31:0]});
          chk("out_overflow", {63'd0, bus.out_overflow}, {63'd0, e[32]});
        end
      end
    end
  end

  // Issue one sample into an idle engine, expect a hand-computed result,
  // and measure the cycle in which out_valid appears (accept cycle = 0)
  task automatic send_one(input logic [31:0] x, input logic [31:0] es, input logic eo);
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_x = x;
    #1;
    chk("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
    exp_q.push_back({eo, es});
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
      #1;
    end while (!bus.out_valid && lat < 50);
    chk("latency", 64'(lat), 64'd9);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  logic [31:0] vec [12] = '{32'h40000000, 32'hC0000000, 32'h20000000, 32'h7FFFFFFF,
                            32'h80000000, 32'h00000001, 32'h60000000, 32'hA0000000,
                            32'h10000000, 32'hE0000000, 32'h7FFF0000, 32'h00000000};

  initial begin
    int idx, t;
    logic [31:0] held;
    logic stale;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.out_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_sum", {32'd0, bus.out_sum}, 64'd0);
    chk("rst_out_overflow", {63'd0, bus.out_overflow}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

    // Directed single samples (values worked out by hand)
    send_one(32'h00000000, 32'h00000000, 1'b0);
    drain();
    send_one(32'h40000000, 32'h33E15F13, 1'b0);
    drain();
    send_one(32'h80000000, 32'h80000000, 1'b1);
    drain();

    // 12 back-to-back samples: in_ready runs 4 high / 4 low
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.in_valid = (idx < 12);
      bus.in_x = (idx < 12) ? vec[idx] : 32'h0;
      #1;
      chk("in_ready_pattern", {63'd0, bus.in_ready}, {63'd0, ((c / 4) % 2) == 0});
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(vec[idx]));
        idx++;
      end
    end
    @(negedge clk); bus.in_valid = 1'b0;
    chk("stream_accepted", 64'(idx), 64'd12);
    drain();

    // Backpressure: 4 in flight, output held for 20 cycles
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_x = vec[i + 6];
      #1;
      chk("in_ready_fill", {63'd0, bus.in_ready}, 64'd1);
      exp_q.push_back(model(vec[i + 6]));
    end
    @(negedge clk); bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 50) begin @(negedge clk); #1; t++; end
    chk("stall_first_result", {63'd0, bus.out_valid}, 64'd1);
    held = bus.out_sum;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("stall_out_sum", {32'd0, bus.out_sum}, {32'd0, held});
      chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    #1;
    chk("release_v0", {63'd0, bus.out_valid}, 64'd1);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk); #1;
      chk("release_consecutive", {63'd0, bus.out_valid}, 64'd1);
    end
    @(negedge clk); #1;
    chk("release_done", {63'd0, bus.out_valid}, 64'd0);
    drain();

    // Asynchronous reset with 3 samples mid-evaluation
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_x = vec[i];
    end
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("busy_before_rst", {63'd0, bus.busy}, 64'd1);
    #2; rst = 1'b1;
    #1;
    chk("async_rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("async_rst_out_sum", {32'd0, bus.out_sum}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      if (bus.out_valid || bus.busy) stale = 1'b1;
    end
    chk("no_stale_after_rst", {63'd0, stale}, 64'd0);
    send_one(32'h40000000, 32'h33E15F13, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop if something wedges
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
